mem_stage_sram_ctrl: RTL
========================

Name: mem_stage_sram_ctrl

Overview:
- Data-memory access controller for the MEM stage of the pipelined core.
- Sits between the EX/MEM pipeline outputs (alu_res as address, Rm value as store data, MEM_R_EN/MEM_W_EN) and the external 16-bit asynchronous SRAM.
- Splits each 32-bit load/store into two half-word SRAM accesses with programmable wait states.
- Returns load data to the MEM/WB register and raises a ready signal; the hazard/freeze logic stalls all upstream stages while ready is low.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 3: clock cycles per half-word access phase; legal range 1..15.
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- rd_en  in  1  load request (MEM_R_EN).
- wr_en  in  1  store request (MEM_W_EN).
- addr  in  32  byte address (alu_res).
- wdata  in  32  store data.
- rdata  out  32  load data, registered.
- ready  out  1  combinational; high = pipeline may advance.
- sram_addr  out  SRAM_AW  half-word address.
- sram_dq_out  out  16  write data to pad.
- sram_dq_in  in  16  read data from pad.
- sram_dq_oe  out  1  pad output enable.
- sram_we_n  out  1  SRAM write strobe, active-low.

Behaviour:
- Reset is asynchronous, active-high, on clock clk.
- Reset values:
  - state = IDLE, counter = 0, rdata = 0.
  - sram_we_n = 1, sram_dq_oe = 0, sram_addr = 0, sram_dq_out = 0.
  - Latched address and data registers = 0.
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - With rd_en|wr_en high: latch addr, wdata, and op (write if wr_en, else read), go to LO, counter = 0.
  - rd_en and wr_en both high is illegal; it is treated as a write.
- LO, HI:
  - Each state lasts exactly WAIT_CYCLES cycles, counted by counter. Transition when counter == WAIT_CYCLES-1, and counter clears on the transition.
  - LO transitions to HI; HI transitions to DONE.
- DONE: one cycle, then IDLE unconditionally. Requests are not sampled in DONE.
- Address math:
  - word = (addr_latched - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits; addr[1:0] ignored.
  - LO phase: sram_addr = {word, 0}. HI phase: sram_addr = {word, 1}.
  - No range check; addresses wrap modulo the SRAM size.
- Writes:
  - sram_dq_oe = 1 and sram_we_n = 0 for all cycles of LO and HI.
  - sram_dq_out = wdata[15:0] in LO, wdata[31:16] in HI.
  - sram_we_n = 1 in IDLE and DONE.
- Reads:
  - sram_dq_oe = 0 and sram_we_n = 1.
  - sram_dq_in is sampled into rdata[15:0] on the last LO cycle and into rdata[31:16] on the last HI cycle.
- rdata holds its value through writes and idle cycles; it is only updated by reads.
- ready:
  - ready = (IDLE & ~rd_en & ~wr_en) | DONE.
  - A request presented in IDLE drops ready in that same cycle.
- Latency:
  - Request cycle t0 (IDLE), LO t1..tN, HI tN+1..t2N, DONE at t2N+1, with N = WAIT_CYCLES.
  - ready is low for 2N+1 cycles (7 at default).
  - rdata is complete in DONE and is captured by MEM/WB at the end of DONE.
- Inputs are stable while ready is low, because upstream is frozen.
- Back-to-back memory ops: the next request is seen in the IDLE cycle after DONE, so there is a minimum 1-cycle IDLE gap.
- Reset mid-access: the FSM returns to IDLE immediately, the write strobe deasserts asynchronously, and the partial write is abandoned. rdata = 0.

Test Plan:
- Reset then idle, no requests -> ready=1 every cycle, sram_we_n=1, sram_dq_oe=0, rdata=0.
- Store addr=1024+8, wdata=0xDEADBEEF, WAIT_CYCLES=3 -> sram_addr=4 with dq_out=0xBEEF and we_n=0 for 3 cycles; then sram_addr=5 with dq_out=0xDEAD for 3 cycles; ready low 7 cycles, high in the 8th.
- Load same address with SRAM model returning the stored halves -> rdata=0xDEADBEEF in DONE; ready pulse 1 cycle; rdata unchanged afterwards.
- Back-to-back load then store held on inputs -> DONE, one IDLE cycle (ready=0 because the new request is present), then LO begins; no request is sampled during DONE.
- Assert rst during HI of a store -> we_n=1 and dq_oe=0 immediately, state IDLE, ready=1 once rst is released with no request; SRAM upper half not written.
- rd_en=wr_en=1, addr=1024, wdata=0x12345678 -> write performed (halves 0x5678 then 0x1234 at sram_addr 0 and 1), rdata unchanged.

Source files
------------

// File: rtl/mem_stage_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_sram_ctrl
// Purpose  : MEM-stage data-memory controller. Splits each 32-bit load/store
//            into two 16-bit accesses (low half, then high half) on an
//            external asynchronous SRAM. Each half-word phase lasts
//            WAIT_CYCLES clocks. ready is held low for the whole access so the
//            hazard logic freezes the upstream pipeline.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            rd_en_i, wr_en_i  - load / store request (both high = store)
//            addr_i, wdata_i   - byte address and store data
//            rdata_o           - registered load data
//            ready_o           - combinational, high = pipeline may advance
//            sram_addr_o       - half-word address to the SRAM
//            sram_dq_out_o / sram_dq_in_i / sram_dq_oe_o - data pad
//            sram_we_n_o       - active-low write strobe
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_sram_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 3,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en_i,
  input  logic               wr_en_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               ready_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [15:0]        sram_dq_out_o,
  input  logic [15:0]        sram_dq_in_i,
  output logic               sram_dq_oe_o,
  output logic               sram_we_n_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0]  C_CNT_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] C_BASE     = 32'(BASE_ADDR);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wr_q,    wr_d;

  // Offset from the SRAM base; bits [SRAM_AW:2] form the word index, which
  // wraps naturally because the upper bits are simply dropped.
  logic [31:0]        w_off;
  logic [SRAM_AW-2:0] w_word;
  logic               w_last;
  logic               w_unused_off;

  assign w_off        = addr_q - C_BASE;
  assign w_word       = w_off[SRAM_AW:2];
  assign w_last       = (cnt_q == C_CNT_LAST);
  assign w_unused_off = ^{w_off[31:SRAM_AW+1], w_off[1:0]};
  assign rdata_o      = rdata_q;

  // Asynchronous reset forces IDLE, so the decoded strobe and output enable
  // drop immediately and any half-finished write is abandoned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    wr_d          = wr_q;
    ready_o       = 1'b0;
    sram_addr_o   = '0;
    sram_dq_out_o = 16'd0;
    sram_dq_oe_o  = 1'b0;
    sram_we_n_o   = 1'b1;

    case (state_q)
      S_IDLE: begin
        // A request pulls ready low in the same cycle it is presented.
        ready_o = ~(rd_en_i | wr_en_i);
        if (rd_en_i | wr_en_i) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          wr_d    = wr_en_i;   // simultaneous rd/wr resolves to a store
          cnt_d   = 4'd0;
          state_d = S_LO;
        end
      end

      S_LO: begin
        sram_addr_o = {w_word, 1'b0};
        if (wr_q) begin
          sram_dq_oe_o  = 1'b1;
          sram_we_n_o   = 1'b0;
          sram_dq_out_o = wdata_q[15:0];
        end
        if (w_last) begin
          cnt_d   = 4'd0;
          state_d = S_HI;
          if (!wr_q) begin
            rdata_d[15:0] = sram_dq_in_i;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_HI: begin
        sram_addr_o = {w_word, 1'b1};
        if (wr_q) begin
          sram_dq_oe_o  = 1'b1;
          sram_we_n_o   = 1'b0;
          sram_dq_out_o = wdata_q[31:16];
        end
        if (w_last) begin
          cnt_d   = 4'd0;
          state_d = S_DONE;
          if (!wr_q) begin
            rdata_d[31:16] = sram_dq_in_i;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_DONE: begin
        // Single release cycle; requests are deliberately not sampled here.
        ready_o = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
